// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: one memory operation per cycle, reads checked through a 2-stage return pipeline.
// Optional build macro MBIST_STOP_ON_FAIL_EN aborts the march at the first miscompare and drains in-flight reads.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            err_cnt,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, PRE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              elem, adv_elem;
  logic [ADDR_WIDTH-1:0]   addr, adv_addr;
  logic                    phase, adv_phase;
  logic                    last_op, two_op, down;
  logic                    drain_cnt;
  logic                    accept, mismatch;
  logic                    rd_valid1, rd_valid2, rd_exp1, rd_exp2;
  logic [2:0]              rd_elem1, rd_elem2;
  logic [ADDR_WIDTH-1:0]   rd_addr1, rd_addr2;

  // Element/phase decode: E0 is w0 only, E5 is r0 only, the rest are read-then-write pairs.
  function automatic logic op_write(input logic [2:0] e, input logic ph);
    case (e)
      3'd0:    return 1'b1;
      3'd5:    return 1'b0;
      default: return ph;
    endcase
  endfunction

  function automatic logic op_bit(input logic [2:0] e, input logic ph);
    case (e)
      3'd1, 3'd3: return ph;
      3'd2, 3'd4: return ~ph;
      default:    return 1'b0;
    endcase
  endfunction

  assign accept   = (state == IDLE) && start;
  assign mismatch = rd_valid2 && (rdata != {DATA_WIDTH{rd_exp2}});

  // Position of the operation following the current one in the march.
  always_comb begin
    adv_elem  = elem;
    adv_addr  = addr;
    adv_phase = 1'b0;
    last_op   = 1'b0;
    two_op    = (elem != 3'd0) && (elem != 3'd5);
    down      = (elem == 3'd3) || (elem == 3'd4);
    if (two_op && !phase) begin
      adv_phase = 1'b1;
    end else if (down ? (addr != '0) : (addr != LAST_ADDR)) begin
      adv_addr = down ? addr - ADDR_ONE : addr + ADDR_ONE;
    end else if (elem == 3'd5) begin
      last_op = 1'b1;
    end else begin
      adv_elem = elem + 3'd1;
      adv_addr = ((elem == 3'd2) || (elem == 3'd3)) ? LAST_ADDR : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and memory-port outputs; wdata always carries the next operation's write word.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    write_read = 1'b0;
    address    = '0;
    wdata      = '0;
    case (state)
      IDLE: if (start) state_nxt = PRE;
      PRE: begin
        busy      = 1'b1;
        state_nxt = RUN;
        if (op_write(elem, phase)) wdata = {DATA_WIDTH{op_bit(elem, phase)}};
      end
      RUN: begin
        busy       = 1'b1;
        write_read = op_write(elem, phase);
        address    = addr;
        if (!last_op && op_write(adv_elem, adv_phase))
          wdata = {DATA_WIDTH{op_bit(adv_elem, adv_phase)}};
        if (last_op) state_nxt = DRAIN;
`ifdef MBIST_STOP_ON_FAIL_EN
        if (mismatch) state_nxt = DRAIN;
`endif
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem      <= '0;
      addr      <= '0;
      phase     <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (accept) begin
        elem  <= '0;
        addr  <= '0;
        phase <= 1'b0;
      end else if (state == RUN) begin
        elem  <= adv_elem;
        addr  <= adv_addr;
        phase <= adv_phase;
      end
    end
  end

  // Each read's expectation travels two stages so it lines up with rdata from the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid1 <= 1'b0;
      rd_exp1   <= 1'b0;
      rd_elem1  <= '0;
      rd_addr1  <= '0;
      rd_valid2 <= 1'b0;
      rd_exp2   <= 1'b0;
      rd_elem2  <= '0;
      rd_addr2  <= '0;
    end else begin
      rd_valid1 <= (state == RUN) && !op_write(elem, phase);
      rd_exp1   <= op_bit(elem, phase);
      rd_elem1  <= elem;
      rd_addr1  <= addr;
      rd_valid2 <= rd_valid1;
      rd_exp2   <= rd_exp1;
      rd_elem2  <= rd_elem1;
      rd_addr2  <= rd_addr1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      err_cnt   <= '0;
    end else if (mismatch) begin
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= rd_addr2;
        fail_elem <= rd_elem2;
        fail_data <= rdata;
      end
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl: fault-injectable memory model plus a March C- reference walk.
module tb_mbist_march_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CAP = 15;
  localparam int N = CAP + 1;
  localparam int NOPS = 10 * N;
  localparam int F_NONE = 0, F_SA1 = 1, F_SA0 = 2, F_RISE = 3, F_FALL = 4;

  localparam int       E_N    [6] = '{1, 2, 2, 2, 2, 1};
  localparam logic     E_DOWN [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [1:0] E_W  [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  localparam logic [1:0] E_V  [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};

  logic clk, rst, start, busy, done, fail, write_read;
  logic [AW-1:0] fail_addr, address;
  logic [2:0] fail_elem;
  logic [DW-1:0] fail_data, wdata, rdata;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int fault_type = F_NONE;
  int fault_addr = 0;
  int fault_bit = 0;
  logic mem_load;
  logic [DW-1:0] init_img [N];
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wq, rd1;

  logic          op_we   [NOPS];
  logic [AW-1:0] op_addr [NOPS];
  logic [DW-1:0] op_word [NOPS];
  logic          m_fail;
  logic [2:0]    m_elem;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int m_err, m_done, m_nops, m_writes;

  typedef struct {
    int ftype; int faddr; int fbit; int hold;
    logic exp_fail; logic [2:0] exp_elem; logic [AW-1:0] exp_addr; logic [DW-1:0] exp_data;
    int exp_err; int exp_done;
  } vec_t;
  vec_t vecs [5];

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data), .err_cnt(err_cnt),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] apply_write(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v, input int a);
    logic [DW-1:0] r;
    r = new_v;
    if (a == fault_addr) begin
      if (fault_type == F_RISE && !old_v[fault_bit] && new_v[fault_bit]) r[fault_bit] = 1'b0;
      if (fault_type == F_FALL && old_v[fault_bit] && !new_v[fault_bit]) r[fault_bit] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] read_view(input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (a == fault_addr && fault_type == F_SA1) r[fault_bit] = 1'b1;
    if (a == fault_addr && fault_type == F_SA0) r[fault_bit] = 1'b0;
    return r;
  endfunction

  // Memory under test: wdata registered a cycle ahead of the write, two-cycle read return.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < N; i++) mem[i] <= init_img[i];
    end else begin
      wq <= wdata;
      if (write_read) mem[address] <= apply_write(mem[address], wq, int'(address));
      rd1 <= read_view(mem[address], int'(address));
      rdata <= rd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Walks March C- as an ordered list of operations on an array holding the faulty cell behaviour.
  task automatic model_run();
    logic [DW-1:0] shadow [N];
    logic [DW-1:0] word, obs;
    int k, a, j0, nmis;
    int mis_idx [$];
    shadow = init_img;
    k = 0; j0 = -1; nmis = 0;
    m_fail = 1'b0; m_elem = '0; m_addr = '0; m_data = '0;
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < N; s++) begin
        a = E_DOWN[e] ? CAP - s : s;
        for (int o = 0; o < E_N[e]; o++) begin
          word = {DW{E_V[e][o]}};
          if (E_W[e][o]) begin
            shadow[a] = apply_write(shadow[a], word, a);
          end else begin
            obs = read_view(shadow[a], a);
            if (obs !== word) begin
              if (j0 < 0) begin
                j0 = k; m_fail = 1'b1; m_elem = 3'(e); m_addr = AW'(a); m_data = obs;
              end
              mis_idx.push_back(k);
            end
          end
          op_we[k] = E_W[e][o]; op_addr[k] = AW'(a); op_word[k] = word;
          k++;
        end
      end
    end
    m_nops = NOPS;
    m_done = NOPS + 4;
`ifdef MBIST_STOP_ON_FAIL_EN
    if (j0 >= 0) begin
      m_nops = (j0 + 3 < NOPS) ? j0 + 3 : NOPS;
      m_done = (j0 + 7 < NOPS + 4) ? j0 + 7 : NOPS + 4;
    end
`endif
    foreach (mis_idx[i]) if (mis_idx[i] < m_nops) nmis++;
    m_err = (nmis > 255) ? 255 : nmis;
    m_writes = 0;
    for (int j = 0; j < m_nops; j++) if (op_we[j]) m_writes++;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) init_img[i] = DW'($urandom);
    @(negedge clk); mem_load = 1'b1;
    @(negedge clk); mem_load = 1'b0;
    model_run();
  endtask

  task automatic checkOutput(input string name, input int hold, output logic a_fail, output logic [2:0] a_elem,
                             output logic [AW-1:0] a_addr, output logic [DW-1:0] a_data, output logic [7:0] a_err,
                             output int a_done);
    int cyc, busy_bad, done_cnt, seq_bad, clear_bad, writes, j;
    logic ok;
    cyc = 0; busy_bad = 0; done_cnt = 0; seq_bad = 0; clear_bad = 0; writes = 0; a_done = -1;
    a_fail = 1'b0; a_elem = '0; a_addr = '0; a_data = '0; a_err = '0;
    start = 1'b1;
    @(posedge clk);
    while (cyc < m_done + 6) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) start = 1'b0;
      if (busy !== (cyc >= 1 && cyc < m_done)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (a_done < 0) a_done = cyc;
      end
      if (cyc == 1 && (fail !== 1'b0 || err_cnt !== 8'd0)) clear_bad++;
      if (cyc == 1) begin
        ok = (write_read === 1'b0) && (address === '0) && (wdata === op_word[0]);
      end else if (cyc >= 2 && cyc <= m_nops + 1) begin
        j = cyc - 2;
        ok = (write_read === op_we[j]) && (address === op_addr[j]);
        if (j + 1 < m_nops && op_we[j + 1]) ok = ok && (wdata === op_word[j + 1]);
      end else begin
        ok = (write_read === 1'b0) && (address === '0) && (wdata === '0);
      end
      if (!ok) seq_bad++;
      if (write_read === 1'b1) writes++;
      if (cyc == m_done) begin
        a_fail = fail; a_elem = fail_elem; a_addr = fail_addr; a_data = fail_data; a_err = err_cnt;
      end
    end
    start = 1'b0;
    check({name, ".busy"}, 64'(busy_bad), 64'd0);
    check({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
    check({name, ".done_cycle"}, 64'(a_done), 64'(m_done));
    check({name, ".op_sequence"}, 64'(seq_bad), 64'd0);
    check({name, ".writes"}, 64'(writes), 64'(m_writes));
    check({name, ".start_clears"}, 64'(clear_bad), 64'd0);
    check({name, ".fail"}, 64'(a_fail), 64'(m_fail));
    check({name, ".fail_elem"}, 64'(a_elem), 64'(m_elem));
    check({name, ".fail_addr"}, 64'(a_addr), 64'(m_addr));
    check({name, ".fail_data"}, 64'(a_data), 64'(m_data));
    check({name, ".err_cnt"}, 64'(a_err), 64'(m_err));
  endtask

  initial begin
    logic r_fail;
    logic [2:0] r_elem;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [7:0] r_err;
    int r_done, bad, cyc;

    vecs[0] = '{F_NONE, 0, 0, 1,  1'b0, 3'd0, 4'd0, 8'h00, 0, 164};
`ifdef MBIST_STOP_ON_FAIL_EN
    vecs[1] = '{F_SA1,  9, 0, 1,  1'b1, 3'd1, 4'd9, 8'h01, 1, 41};
    vecs[3] = '{F_RISE, 5, 3, 1,  1'b1, 3'd2, 4'd5, 8'hF7, 1, 65};
`else
    vecs[1] = '{F_SA1,  9, 0, 1,  1'b1, 3'd1, 4'd9, 8'h01, 3, 164};
    vecs[3] = '{F_RISE, 5, 3, 1,  1'b1, 3'd2, 4'd5, 8'hF7, 2, 164};
`endif
    vecs[2] = '{F_NONE, 0, 0, 1,  1'b0, 3'd0, 4'd0, 8'h00, 0, 164};
    vecs[4] = '{F_NONE, 0, 0, 20, 1'b0, 3'd0, 4'd0, 8'h00, 0, 164};

    rst = 1'b1; start = 1'b0; mem_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({busy, done, fail, fail_addr, fail_elem, fail_data, err_cnt, write_read, address, wdata}), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      fault_type = vecs[i].ftype; fault_addr = vecs[i].faddr; fault_bit = vecs[i].fbit;
      applyStimulus();
      checkOutput($sformatf("vec%0d", i), vecs[i].hold, r_fail, r_elem, r_addr, r_data, r_err, r_done);
      check($sformatf("vec%0d.tbl_fail", i), 64'(r_fail), 64'(vecs[i].exp_fail));
      check($sformatf("vec%0d.tbl_elem", i), 64'(r_elem), 64'(vecs[i].exp_elem));
      check($sformatf("vec%0d.tbl_addr", i), 64'(r_addr), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d.tbl_data", i), 64'(r_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d.tbl_err", i), 64'(r_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d.tbl_done", i), 64'(r_done), 64'(vecs[i].exp_done));
    end

    // Abort a faulty run in cycle 50 with reset, then confirm a clean full run follows.
    fault_type = F_SA1; fault_addr = 9; fault_bit = 0;
    applyStimulus();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("abort.before_reset_fail", 64'(fail), 64'd1);
    rst = 1'b1;
    #1;
    check("abort.outputs_zero",
          64'({busy, done, fail, fail_addr, fail_elem, fail_data, err_cnt, write_read, address, wdata}), 64'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort.no_done", 64'(bad), 64'd0);
    fault_type = F_NONE;
    applyStimulus();
    checkOutput("post_reset", 1, r_fail, r_elem, r_addr, r_data, r_err, r_done);
    check("post_reset.done_164", 64'(r_done), 64'd164);

    for (int t = 0; t < 8; t++) begin
      fault_type = int'($urandom_range(0, 4));
      fault_addr = int'($urandom_range(0, CAP));
      fault_bit  = int'($urandom_range(0, DW - 1));
      applyStimulus();
      checkOutput($sformatf("rand%0d_f%0d_a%0d_b%0d", t, fault_type, fault_addr, fault_bit),
                  int'($urandom_range(1, 5)), r_fail, r_elem, r_addr, r_data, r_err, r_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- memory built-in self-test controller that drives the `write_read`/`address`/`wdata` port of a single-port test memory and checks the returned `rdata`. The controller sits between the BIST top level and the memory under test, which is either fault-free or fault-injected. It issues one memory operation per cycle and compares read data through a 2-cycle return pipeline. It reports pass/fail, the first failing address, element and data, and a saturating error count.

## Interface
Parameters:
- `DATA_WIDTH`, 8: memory word width.
- `ADDR_WIDTH`, 4: memory address width.
- `CAPACITY`, 15: highest address tested. N = CAPACITY+1 words, swept from 0 to CAPACITY.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: starts a test when sampled high in IDLE.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done`.
- `done`, output, 1: one-cycle pulse at the end of the test.
- `fail`, output, 1: sticky; at least one miscompare occurred. Cleared on accepted `start`.
- `fail_addr`, output, ADDR_WIDTH: address of the first miscompare.
- `fail_elem`, output, 3: March element index (0–5) of the first miscompare.
- `fail_data`, output, DATA_WIDTH: observed `rdata` at the first miscompare.
- `err_cnt`, output, 8: miscompare count, saturating at 255.
- `write_read`, output, 1: to memory. 1 = write, 0 = read.
- `address`, output, ADDR_WIDTH: to memory.
- `wdata`, output, DATA_WIDTH: to memory.
- `rdata`, input, DATA_WIDTH: from memory.

## Operation
- March C- sequence, with w0/r0 using all-zeros and w1/r1 using all-ones:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
  - Total 10·N operations.
- Within E1–E4, both operations on one address complete before the address steps. ⇑ runs 0→CAPACITY; ⇓ runs CAPACITY→0.
- FSM states and transitions:
  - IDLE: `start`=1 → PRE.
  - PRE: one cycle. Presents the first write data, issues a read. → RUN.
  - RUN: one operation per cycle. After the last E5 read → DRAIN.
  - DRAIN: 2 cycles, waiting for outstanding reads. → DONE.
  - DONE: one cycle, `done`=1. → IDLE.
- Accepting `start` clears `fail`, `fail_addr`, `fail_elem`, `fail_data` and `err_cnt`. `start` is ignored in every state except IDLE.
- Each read carries its expected word, element index and address through a 2-stage pipeline that is aligned to the memory's read latency.
- On the first miscompare: set `fail` and capture `fail_addr`, `fail_elem` and `fail_data`. These stay frozen until the next start.
- Every miscompare increments `err_cnt`, which saturates at 255.
- Outside PRE/RUN, the controller drives `write_read`=0, `address`=0 and `wdata`=0.
- Reset values: `busy`, `done`, `fail`, `fail_addr`, `fail_elem`, `fail_data`, `err_cnt`, `write_read`, `address` and `wdata` are all 0. State is IDLE.
- Reset asserted mid-test aborts immediately to these values. No `done` pulse is produced for the aborted test.

## Timing
- An operation issued in cycle k drives `write_read` and `address` in cycle k.
- Write data for that operation is driven on `wdata` in cycle k−1, because the memory registers `wdata` one cycle before use. The controller therefore drives `wdata` one operation ahead.
- Read issued in cycle k: `rdata` is valid in cycle k+2 and is compared at the end of cycle k+2.
- Counting the edge that samples `start` as edge 0:
  - PRE = cycle 1.
  - RUN = cycles 2 to 10N+1.
  - DRAIN = cycles 10N+2 to 10N+3.
  - `done` = cycle 10N+4.
- N=16 → `done` in cycle 164. `busy` is high in cycles 1 to 10N+3.
- `fail` and `err_cnt` are final when `done` is high.

## Configuration
- `MBIST_STOP_ON_FAIL_EN` defined:
  - On the first miscompare, RUN stops issuing operations and goes to DRAIN. `done` pulses 3 cycles after the failing compare.
  - `err_cnt` counts the first miscompare plus any reads already in flight.
- Not defined: the full sequence always runs, and `done` timing is fixed at 10N+4.

## Test plan
- Fault-free memory, N=16, pulse `start` → `done` in cycle 164, `busy` high cycles 1–163, `fail`=0, `err_cnt`=0, exactly 160 memory operations issued.
- Bit 0 of address 9 stuck-at-1 → `fail`=1, `fail_elem`=1, `fail_addr`=9, `fail_data`=8'h01, `err_cnt`=3 (E1, E3 and E5 r0 reads), `done` still in cycle 164.
- Rising-transition fault on bit 3 at address 5 (0→1 write fails) → `fail_elem`=2, `fail_addr`=5, `fail_data`=8'hF7, `err_cnt`=2 (E2 and E4).
- `start` held high for 20 cycles → exactly one test runs, one `done` pulse. A second `start` after `done` clears `fail` and `err_cnt` from the prior run.
- `rst` asserted in cycle 50 of a run → all outputs 0 in the same cycle, no `done` pulse. A new `start` then runs a full 164-cycle test.
- With `MBIST_STOP_ON_FAIL_EN` and the stuck-at-1 at address 9 → first miscompare in E1 at address 9, `done` 3 cycles later, `busy` low afterwards, `fail_elem`=1.
